// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared states, ALU ops, instruction fields and select encodings
package arm_mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
    return cmd == CMD_ADD ? ALU_ADD : cmd == CMD_SUB ? ALU_SUB :
           cmd == CMD_AND ? ALU_AND : cmd == CMD_ORR ? ALU_ORR : ALU_ADD;
  endfunction
endpackage

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register and condition-code evaluation
module cond_unit import arm_mc_pkg::*; #(
  parameter logic COND_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_we,
  input  logic       flag_cv,
  output logic       cond_ex
);
  logic [3:0] flags;
  logic n, z, c, v, ge;
  logic [15:0] tab;
  assign {n, z, c, v} = flags;
  assign ge = n == v;
  // Indexed by the condition field: EQ at bit 0 up to NV at bit 15
  assign tab = {1'b0, 1'b1, z | !ge, !z & ge, !ge, ge, !c | z, c & !z,
                !v, v, !n, n, !c, c, !z, z};
  assign cond_ex = !COND_EN || tab[cond];
  always_ff @(posedge clk)
    if (reset) flags <= 4'b0000;
    else if (flag_we) flags <= flag_cv ? alu_flags : {alu_flags[3:2], flags[1:0]};
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM control FSM driving datapath selects and enables
module arm_multicycle_ctrl import arm_mc_pkg::*; #(
  parameter logic COND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite
);
  state_t state, state_nxt, st;
  logic [3:0] cond, rd;
  logic [1:0] op, alu_op;
  logic [5:0] funct;
  logic cond_ex, rd_pc, exec, unused_rn;
  assign cond = Instr[19:16];
  assign op = Instr[15:14];
  assign funct = Instr[13:8];
  assign rd = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign rd_pc = rd == 4'd15;
  assign alu_op = alu_dec(funct[4:1]);
  assign exec = !reset && (state == EXECR || state == EXECI);
  assign ImmSrc = op;
  assign RegSrc = {op == OP_MEM, op == OP_BR};
  cond_unit #(.COND_EN(COND_EN)) u_cond (
    .clk(clk), .reset(reset), .cond(cond), .alu_flags(ALUFlags),
    .flag_we(exec && funct[0] && cond_ex),
    .flag_cv(alu_op == ALU_ADD || alu_op == ALU_SUB),
    .cond_ex(cond_ex)
  );
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= state_nxt;
  // Under reset the decode is forced to FETCH so selects look like a fresh fetch
  always_comb begin
    st = reset ? FETCH : state;
    state_nxt = FETCH;
    PCWrite = 1'b0;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_WD;
    ALUControl = ALU_ADD;
    RegWrite = 1'b0;
    case (st)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        PCWrite = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        state_nxt = op == OP_DP ? (funct[5] ? EXECI : EXECR) :
                    op == OP_MEM ? MEMADR : op == OP_BR ? BRANCH : FETCH;
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_nxt = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite = cond_ex && !rd_pc;
        PCWrite = cond_ex && rd_pc;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemWrite = cond_ex;
      end
      EXECR, EXECI: begin
        ALUSrcB = st == EXECI ? SRCB_IMM : SRCB_WD;
        ALUControl = alu_op;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        RegWrite = cond_ex && !rd_pc;
        PCWrite = cond_ex && rd_pc;
      end
      BRANCH: begin
        ALUSrcB = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite = cond_ex;
      end
      default: state_nxt = FETCH;
    endcase
    if (reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed checks of the multicycle control FSM
module tb_arm_multicycle_ctrl;
  import arm_mc_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic PCWrite2, AdrSrc2, MemWrite2, IRWrite2, ALUSrcA2, RegWrite2;
  logic [1:0] ResultSrc2, ALUSrcB2, ALUControl2, ImmSrc2, RegSrc2;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite)
  );
  arm_multicycle_ctrl #(.COND_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ALUControl(ALUControl2), .ImmSrc(ImmSrc2), .RegSrc(RegSrc2), .RegWrite(RegWrite2)
  );
  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] d);
    return {c, o, f, 4'h0, d};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  localparam logic [19:0] ADDS_I  = mk(4'hE, 2'b00, 6'b101001, 4'd1);
  localparam logic [19:0] LDR     = mk(4'hE, 2'b01, 6'b011001, 4'd3);
  localparam logic [19:0] STR     = mk(4'hE, 2'b01, 6'b011000, 4'd3);
  localparam logic [19:0] SUBS_I  = mk(4'hE, 2'b00, 6'b100101, 4'd4);
  localparam logic [19:0] BEQ     = mk(4'h0, 2'b10, 6'b100000, 4'd0);
  localparam logic [19:0] ANDS_R  = mk(4'hE, 2'b00, 6'b000001, 4'd5);
  localparam logic [19:0] SUB_PC  = mk(4'hE, 2'b00, 6'b100100, 4'd15);
  localparam logic [19:0] ORRS_NV = mk(4'hF, 2'b00, 6'b111001, 4'd1);
  localparam logic [19:0] NOP     = mk(4'hE, 2'b11, 6'b000000, 4'd0);
  initial begin
    repeat (3) tick();
    chk("rst_pcwrite", 32'(PCWrite), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_srcb", 32'(ALUSrcB), 2);
    chk("rst_srca", 32'(ALUSrcA), 1);
    reset = 1'b0;
    #1;
    chk("fetch0_state", 32'(dut.state), 32'(FETCH));
    chk("fetch0_pcwrite", 32'(PCWrite), 1);
    chk("fetch0_irwrite", 32'(IRWrite), 1);
    chk("fetch0_adrsrc", 32'(AdrSrc), 0);
    chk("fetch0_flags", 32'(dut.u_cond.flags), 0);
    Instr = ADDS_I;
    tick();
    chk("adds_decode", 32'(dut.state), 32'(DECODE));
    chk("adds_dec_res", 32'(ResultSrc), 2);
    tick();
    chk("adds_execi", 32'(dut.state), 32'(EXECI));
    chk("adds_srcb", 32'(ALUSrcB), 1);
    chk("adds_srca", 32'(ALUSrcA), 0);
    chk("adds_aluctl", 32'(ALUControl), 0);
    ALUFlags = 4'b0100;
    tick();
    chk("adds_aluwb", 32'(dut.state), 32'(ALUWB));
    chk("adds_regwrite", 32'(RegWrite), 1);
    chk("adds_pcwrite", 32'(PCWrite), 0);
    chk("adds_res", 32'(ResultSrc), 0);
    chk("adds_flags", 32'(dut.u_cond.flags), 4'b0100);
    ALUFlags = 4'b0000;
    tick();
    chk("adds_done", 32'(dut.state), 32'(FETCH));
    Instr = LDR;
    tick();
    tick();
    chk("ldr_memadr", 32'(dut.state), 32'(MEMADR));
    chk("ldr_srcb", 32'(ALUSrcB), 1);
    chk("ldr_immsrc", 32'(ImmSrc), 1);
    chk("ldr_regsrc", 32'(RegSrc), 2);
    tick();
    chk("ldr_memrd", 32'(dut.state), 32'(MEMRD));
    chk("ldr_adrsrc", 32'(AdrSrc), 1);
    chk("ldr_rd_regwrite", 32'(RegWrite), 0);
    tick();
    chk("ldr_memwb", 32'(dut.state), 32'(MEMWB));
    chk("ldr_res", 32'(ResultSrc), 1);
    chk("ldr_regwrite", 32'(RegWrite), 1);
    tick();
    chk("ldr_done", 32'(dut.state), 32'(FETCH));
    Instr = STR;
    tick();
    tick();
    chk("str_memadr_mw", 32'(MemWrite), 0);
    tick();
    chk("str_memwr", 32'(dut.state), 32'(MEMWR));
    chk("str_memwrite", 32'(MemWrite), 1);
    chk("str_adrsrc", 32'(AdrSrc), 1);
    tick();
    chk("str_fetch_mw", 32'(MemWrite), 0);
    chk("str_done", 32'(dut.state), 32'(FETCH));
    Instr = SUBS_I;
    tick();
    tick();
    chk("subs_aluctl", 32'(ALUControl), 1);
    ALUFlags = 4'b0010;
    tick();
    chk("subs_flags", 32'(dut.u_cond.flags), 4'b0010);
    ALUFlags = 4'b0000;
    tick();
    Instr = BEQ;
    tick();
    tick();
    chk("beq_nt_branch", 32'(dut.state), 32'(BRANCH));
    chk("beq_nt_pcwrite", 32'(PCWrite), 0);
    chk("beq_nocond_pcwrite", 32'(PCWrite2), 1);
    chk("beq_srcb", 32'(ALUSrcB), 1);
    chk("beq_res", 32'(ResultSrc), 2);
    chk("beq_regsrc", 32'(RegSrc), 1);
    tick();
    chk("beq_done", 32'(dut.state), 32'(FETCH));
    Instr = ANDS_R;
    tick();
    tick();
    chk("ands_execr", 32'(dut.state), 32'(EXECR));
    chk("ands_srcb", 32'(ALUSrcB), 0);
    chk("ands_aluctl", 32'(ALUControl), 2);
    ALUFlags = 4'b0100;
    tick();
    chk("ands_flags", 32'(dut.u_cond.flags), 4'b0110);
    ALUFlags = 4'b0000;
    tick();
    Instr = BEQ;
    tick();
    tick();
    chk("beq_t_pcwrite", 32'(PCWrite), 1);
    tick();
    Instr = SUB_PC;
    tick();
    tick();
    ALUFlags = 4'b1111;
    tick();
    chk("subpc_pcwrite", 32'(PCWrite), 1);
    chk("subpc_regwrite", 32'(RegWrite), 0);
    chk("subpc_flags", 32'(dut.u_cond.flags), 4'b0110);
    ALUFlags = 4'b0000;
    tick();
    Instr = ORRS_NV;
    tick();
    tick();
    chk("orr_aluctl", 32'(ALUControl), 3);
    ALUFlags = 4'b1001;
    tick();
    chk("nv_regwrite", 32'(RegWrite), 0);
    chk("nv_pcwrite", 32'(PCWrite), 0);
    chk("nv_nocond_regwrite", 32'(RegWrite2), 1);
    chk("nv_flags", 32'(dut.u_cond.flags), 4'b0110);
    ALUFlags = 4'b0000;
    tick();
    Instr = NOP;
    tick();
    chk("nop_decode", 32'(dut.state), 32'(DECODE));
    tick();
    chk("nop_fetch", 32'(dut.state), 32'(FETCH));
    Instr = STR;
    tick();
    tick();
    tick();
    chk("abort_memwr", 32'(dut.state), 32'(MEMWR));
    reset = 1'b1;
    #1;
    chk("abort_memwrite", 32'(MemWrite), 0);
    chk("abort_pcwrite", 32'(PCWrite), 0);
    chk("abort_srcb", 32'(ALUSrcB), 2);
    tick();
    chk("abort_state", 32'(dut.state), 32'(FETCH));
    chk("abort_flags", 32'(dut.u_cond.flags), 0);
    reset = 1'b0;
    #1;
    chk("abort_irwrite", 32'(IRWrite), 1);
    tick();
    chk("abort_decode", 32'(dut.state), 32'(DECODE));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
